// File: rtl/im_loader_pkg.sv
// ---------------------------------------------------------------------------
// im_loader_pkg : shared IM depth and loader state encoding
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package im_loader_pkg;

  localparam int IM_ADDR_WIDTH = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer : big-endian byte-to-word shift register with byte counter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        full
);

  logic [31:0] r_word;
  logic [1:0]  r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else begin
      if (clr)
        r_cnt <= '0;
      else if (shift)
        r_cnt <= r_cnt + 2'd1;
      if (shift)
        r_word <= {r_word[23:0], byte_in};
    end
  end

  // Three bytes already held: the next shift completes the word.
  assign full     = (r_cnt == 2'd3);
  assign word_out = r_word;

endmodule

`default_nettype wire

// File: rtl/im_loader.sv
// ---------------------------------------------------------------------------
// im_loader : length-prefixed byte stream to instruction-memory loader
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module im_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = IM_ADDR_WIDTH,
  parameter int MAX_WORDS  = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [31:0]           im_wdata,
  output logic                  busy,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);

  state_t              r_state;
  logic [15:0]         r_len;
  logic [ADDR_WIDTH:0] r_idx;

  logic [15:0]         w_len;
  logic                w_len_big;
  logic [ADDR_WIDTH:0] w_idx_inc;
  logic                w_last;
  logic                w_shift;
  logic                w_clr;
  logic                w_full;

  assign w_len     = {r_len[15:8], in_data};
  assign w_len_big = ({1'b0, w_len} > 17'(MAX_WORDS));
  assign w_idx_inc = r_idx + 1'b1;
  // Index is one bit wider than the IM so a full-depth load still terminates.
  assign w_last    = (32'(w_idx_inc) == 32'(r_len));

  assign w_shift = (r_state == DATA) && in_valid;
  assign w_clr   = (r_state == LEN_LO) && in_valid && (w_len != 16'd0) && !w_len_big;

  byte_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clr      (w_clr),
    .shift    (w_shift),
    .byte_in  (in_data),
    .word_out (im_wdata),
    .full     (w_full)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) r_state <= LEN_HI;
        LEN_HI: begin
          if (in_valid) begin
            r_len[15:8] <= in_data;
            r_state     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (in_valid) begin
            r_len[7:0] <= in_data;
            if (w_len == 16'd0)
              r_state <= DONE;
            else if (w_len_big)
              r_state <= ERR;
            else begin
              r_idx   <= '0;
              r_state <= DATA;
            end
          end
        end
        DATA: if (in_valid && w_full) r_state <= WRITE;
        WRITE: begin
          r_idx   <= w_idx_inc;
          r_state <= w_last ? DONE : DATA;
        end
        DONE, ERR: if (start) r_state <= LEN_HI;
        default: r_state <= IDLE;
      endcase
    end
  end

  // All outputs decode from the state register; in_valid never reaches in_ready.
  assign in_ready = (r_state == LEN_HI) || (r_state == LEN_LO) || (r_state == DATA);
  assign busy     = in_ready || (r_state == WRITE);
  assign cpu_hold = busy;
  assign im_we    = (r_state == WRITE);
  assign done     = (r_state == DONE);
  assign err      = (r_state == ERR);
  assign im_addr  = r_idx[ADDR_WIDTH-1:0];

endmodule

`default_nettype wire

// File: tb/tb_im_loader.sv
// ---------------------------------------------------------------------------
// tb_im_loader : directed self-checking bench for im_loader
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_im_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        im_we;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;
  int wcount = 0;
  int last_addr = -1;
  logic [31:0] mem [0:1023];
  logic        gaps = 1'b0;

  im_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .busy     (busy),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction-memory model.
  always @(posedge clk) begin
    if (im_we) begin
      mem[im_addr] = im_wdata;
      wcount       = wcount + 1;
      last_addr    = int'(im_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gaps && ($urandom_range(0, 1) == 1)) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $error("FAIL ready_timeout observed=0 expected=1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (!done && !err && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!done && !err) begin
      total++;
      bad++;
      $error("FAIL %s_timeout observed=0 expected=1", tag);
    end
  endtask

  task automatic check_std(input string tag);
    chk({tag, "_w0"}, mem[0], 32'h3C01_0000);
    chk({tag, "_w1"}, mem[1], 32'h3421_0004);
    chk({tag, "_cnt"}, 32'(wcount), 32'd2);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);

    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_we",    {31'd0, im_we},    32'd0);
    chk("rst_busy",  {31'd0, busy},     32'd0);
    chk("rst_hold",  {31'd0, cpu_hold}, 32'd0);
    chk("rst_done",  {31'd0, done},     32'd0);
    chk("rst_err",   {31'd0, err},      32'd0);
    chk("rst_addr",  {22'd0, im_addr},  32'd0);
    chk("rst_wdata", im_wdata,          32'd0);
    reset = 1'b1;
    @(negedge clk);

    // N=2 back-to-back.
    wcount = 0;
    pulse_start();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_hold", {31'd0, cpu_hold}, 32'd1);
    chk("t1_ready", {31'd0, in_ready}, 32'd1);
    send_byte(8'h00); send_byte(8'h02);
    send_word(32'h3C01_0000);
    send_word(32'h3421_0004);
    wait_end("t1");
    check_std("t1");
    chk("t1_ready_done", {31'd0, in_ready}, 32'd0);

    // Same stream with random gaps in in_valid.
    mem[0] = 32'h0; mem[1] = 32'h0; wcount = 0;
    gaps = 1'b1;
    pulse_start();
    chk("t2_done_clr", {31'd0, done}, 32'd0);
    send_byte(8'h00); send_byte(8'h02);
    send_word(32'h3C01_0000);
    send_word(32'h3421_0004);
    wait_end("t2");
    check_std("t2");
    gaps = 1'b0;

    // N=0: done directly after LEN_LO.
    wcount = 0;
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    chk("t3_cnt", 32'(wcount), 32'd0);

    // N=0x0401 exceeds the IM depth.
    pulse_start();
    send_byte(8'h04); send_byte(8'h01);
    chk("t4_err", {31'd0, err}, 32'd1);
    chk("t4_done", {31'd0, done}, 32'd0);
    chk("t4_ready", {31'd0, in_ready}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    chk("t4_cnt", 32'(wcount), 32'd0);
    pulse_start();
    chk("t4_err_clr", {31'd0, err}, 32'd0);
    send_byte(8'h00); send_byte(8'h01);
    send_word(32'hDEAD_BEEF);
    wait_end("t4");
    chk("t4_w0", mem[0], 32'hDEAD_BEEF);
    chk("t4_cnt2", 32'(wcount), 32'd1);
    chk("t4_done2", {31'd0, done}, 32'd1);

    // Reset during word 1 of an N=3 load.
    wcount = 0;
    pulse_start();
    send_byte(8'h00); send_byte(8'h03);
    send_word(32'h1122_3344);
    send_byte(8'h55); send_byte(8'h66);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_ready", {31'd0, in_ready}, 32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);
    chk("t5_addr", {22'd0, im_addr}, 32'd0);
    chk("t5_wdata", im_wdata, 32'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("t5_cnt", 32'(wcount), 32'd1);
    chk("t5_w0", mem[0], 32'h1122_3344);
    chk("t5_we", {31'd0, im_we}, 32'd0);

    // start pulsed mid-DATA is ignored.
    wcount = 0;
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    pulse_start();
    chk("t6_busy", {31'd0, busy}, 32'd1);
    chk("t6_ready", {31'd0, in_ready}, 32'd1);
    send_byte(8'h04);
    send_word(32'h0506_0708);
    wait_end("t6");
    chk("t6_w0", mem[0], 32'h0102_0304);
    chk("t6_w1", mem[1], 32'h0506_0708);
    chk("t6_cnt", 32'(wcount), 32'd2);
    chk("t6_done", {31'd0, done}, 32'd1);

    // Full-depth load, N=1024.
    wcount = 0;
    pulse_start();
    send_byte(8'h04); send_byte(8'h00);
    for (int i = 0; i < 1024; i++) send_word(32'hA500_0000 | 32'(i));
    wait_end("t7");
    chk("t7_cnt", 32'(wcount), 32'd1024);
    chk("t7_last", 32'(last_addr), 32'd1023);
    chk("t7_w0", mem[0], 32'hA500_0000);
    chk("t7_w512", mem[512], 32'hA500_0200);
    chk("t7_w1023", mem[1023], 32'hA500_03FF);
    chk("t7_done", {31'd0, done}, 32'd1);
    chk("t7_err", {31'd0, err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/im_loader.md
# im_loader

Program loader for the instruction memory. Receives a length-prefixed byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Writes those words, one per write strobe, into consecutive IM word slots starting at index 0. Holds the CPU in reset while loading, so the fetch side only ever reads a fully written image.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: IM word-index width (1024 words); matches the IM read index PC[11:2].
- `MAX_WORDS`, default 2**ADDR_WIDTH: largest accepted word count.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `start`, input, 1: one-cycle pulse that begins a load. Only acted on in IDLE, DONE or ERR.
- `in_valid`, input, 1: a byte is present on `in_data`.
- `in_data`, input, 8: stream byte.
- `in_ready`, output, 1: the loader accepts a byte this cycle.
- `im_we`, output, 1: IM write strobe, one cycle per word.
- `im_addr`, output, ADDR_WIDTH: IM word index for the write.
- `im_wdata`, output, 32: word to write.
- `busy`, output, 1: a load is in progress.
- `cpu_hold`, output, 1: equals `busy`; ORed into the CPU reset.
- `done`, output, 1: load completed; held until the next accepted `start` or reset.
- `err`, output, 1: length rejected; held until the next accepted `start` or reset.

## Operation
- **Stream format:** 16-bit word count N, high byte first. Then 4·N data bytes, each word most-significant byte first.
- **Byte acceptance:** a byte is accepted on an edge where `in_valid && in_ready`. Gaps in `in_valid` are legal and only stall the loader.

State machine:
- **IDLE:** waits for `start`; then goes to LEN_HI.
- **LEN_HI:** accepts count[15:8]; then goes to LEN_LO.
- **LEN_LO:** accepts count[7:0]. The next state depends on N:
  - N == 0: go to DONE.
  - N > MAX_WORDS: go to ERR.
  - Otherwise: clear the word index and byte counter, then go to DATA.
- **DATA:** accepts bytes and shifts them in: wdata <= {wdata[23:0], in_data}. A 2-bit byte counter wraps 3 to 0. When the 4th byte is accepted, go to WRITE.
- **WRITE:** `im_we`=1 for one cycle, with `im_addr` = word index and `im_wdata` = assembled word; `in_ready`=0. Afterwards the word index increments. If (index+1) == N, go to DONE; otherwise go to DATA.
- **DONE / ERR:** `done` or `err` is 1 and `in_ready` is 0. A `start` clears the flag and goes to LEN_HI.

Rules:
- `in_ready` is 1 only in LEN_HI, LEN_LO and DATA.
- `busy` is 1 in LEN_HI, LEN_LO, DATA and WRITE.
- `start` is ignored in LEN_HI, LEN_LO, DATA and WRITE.
- **Widths:** N is held in 16 bits. The comparison against MAX_WORDS uses a 17-bit compare. The word index is ADDR_WIDTH+1 bits wide so that N == MAX_WORDS terminates correctly; `im_addr` is its low ADDR_WIDTH bits.
- **Extra bytes:** bytes beyond 4·N are never accepted, because `in_ready` is 0 after DONE.
- **Reset mid-load:** aborts the load at the next edge and returns to IDLE. No further `im_we` is issued. Words already written stay in IM.

## Timing
- **Reset values:** state IDLE; `in_ready`, `im_we`, `busy`, `cpu_hold`, `done`, `err` = 0; `im_addr` = 0; `im_wdata` = 0.
- **Start:** `start` sampled at edge t puts the loader in LEN_HI with `busy`=1 after t.
- **Write latency:** the 4th byte of a word is accepted at edge t. `im_we` is high during cycle t..t+1. IM captures the word at edge t+1.
- **Throughput:** at most 4 bytes per 5 cycles.
- **Completion:** `done`=1 and `busy`=0 from the edge that completes the last WRITE cycle. With N=0, this happens directly after LEN_LO.
- **Outputs:** all are registered or decoded from state only; there is no combinational path from `in_valid` to `in_ready`.

## Structure
- **Shared package `im_loader_pkg`:**
  - state encoding constants IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR (3 bits);
  - `IM_ADDR_WIDTH` = 10, shared with the IM so both agree on depth.
- **Sub-module `byte_packer`:** shift register plus 2-bit byte counter, with ports `clk`, `reset`, `clr`, `shift`, `byte_in`, `word_out`, `full`. The FSM stays in `im_loader`.

## Test plan
- N=2, bytes 00 02 3C 01 00 00 34 21 00 04 sent back-to-back → writes idx0=0x3C010000 and idx1=0x34210004, exactly two `im_we` pulses, then `done`=1 and `busy`=0.
- Same stream with `in_valid` low on random cycles (~50%) → identical writes; no write while `in_valid` is low in DATA.
- N=0 (00 00) → no `im_we`; `done`=1 the cycle after LEN_LO accepts its byte.
- N=0x0401 with ADDR_WIDTH=10 → `err`=1, no writes, `in_ready`=0; a later `start` with a valid stream loads correctly and `err` clears.
- `reset` low after 2 bytes of word 1 of an N=3 load → no further `im_we`; all outputs at reset values; idx0 retains its word.
- `start` pulsed during DATA → ignored; the load completes normally. N=1024 → last write at idx 1023, then `done`.
